mac_tx_sched: RTL and testbench
===============================

// Module: mac_tx_sched
// PURPOSE
//  Multi-channel TX frame scheduler between protocol encoders (ARP reply, IPv4, ...) and rgmii_tx.
//  Generalises the single-client ARP reply path to NUM_CH clients.
//  Adds fixed-priority/round-robin arbitration, per-channel hold gating, inter-frame gap
//  enforcement and stall-timeout abort.
//  Sits in the MAC top level on the TX clock domain; rgmii_tx receives the multiplexed byte stream.
// PARAMETERS
//  NUM_CH     4   number of client channels, 1..8
//  ARB_MODE   0   0 = fixed priority (ch0 highest), 1 = round-robin (search starts after last grant)
//  IFG_CYCLES 12  idle cycles forced after every frame end or abort, >=1
//  STALL_MAX  64  consecutive tx_next cycles without ch_valid before abort, >=1
// PORTS
//  clk          in   1          TX clock
//  rst_n        in   1          asynchronous reset, active-low
//  ch_req       in   NUM_CH     level: channel has a frame to send
//  ch_hold      in   NUM_CH     level: channel not yet eligible (e.g. rx still busy / CRC pending)
//  ch_dest      in   NUM_CH*48  per-channel destination MAC, ch i at [48*i+:48]
//  ch_ethertype in   NUM_CH*16  per-channel ethertype, ch i at [16*i+:16]
//  ch_data      in   NUM_CH*8   per-channel payload byte
//  ch_valid     in   NUM_CH     ch_data valid
//  ch_last      in   NUM_CH     ch_data is final payload byte
//  ch_ready     out  NUM_CH     byte accepted this cycle (combinational)
//  ch_grant     out  NUM_CH     one-hot, registered: channel owns the TX path
//  tx_en        out  1          to rgmii_tx mac_phy_txen
//  tx_dest      out  48         to rgmii_tx mac_dest
//  tx_ethertype out  16         to rgmii_tx ethertype
//  tx_data      out  8          to rgmii_tx mac_phy_txd
//  tx_next      in   1          from rgmii_tx send_next: next payload byte requested
//  tx_abort     out  1          1-cycle pulse: frame aborted on stall
//  frame_cnt    out  16         completed frames, wraps at 2^16
//  abort_cnt    out  16         aborted frames, wraps at 2^16
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = NUM_CH-1 (first rr search starts at ch0); applied asynchronously.
//  Eligible channel: ch_req[i] & ~ch_hold[i].
//  IDLE
//   - any channel eligible -> pick winner per ARB_MODE.
//   - register ch_grant, tx_dest, tx_ethertype from winner; tx_en<=1; -> SEND.
//   - grant latency: 1 cycle from eligibility.
//  SEND
//   - ch_ready[g] = tx_next & ch_valid[g]; all other ch_ready bits = 0.
//   - on handshake: tx_data<=ch_data[g] (visible next cycle); stall counter cleared.
//   - handshake with ch_last[g]: tx_en<=0, ch_grant<=0, frame_cnt++, -> IFG.
//   - tx_next & ~ch_valid[g]: stall counter++.
//     Reaching STALL_MAX: tx_en<=0, ch_grant<=0, tx_abort pulse, abort_cnt++, -> IFG.
//   - cycles with tx_next=0 neither count nor clear the stall counter.
//   - ch_req/ch_hold changes during SEND are ignored; tx_dest/tx_ethertype stay stable until the frame ends.
//  IFG
//   - hold for exactly IFG_CYCLES cycles, then -> IDLE.
//   - requests arriving during IFG wait; next grant occurs no earlier than IFG_CYCLES+1 cycles after frame end.
//  Round-robin
//   - pointer updates to the granted index at grant time.
//   - search order ptr+1 .. ptr+NUM_CH, modulo NUM_CH.
//  Edge cases
//   - last and stall limit in the same cycle: last wins (frame counted as sent).
//   - NUM_CH=1: arbitration degenerates to pass-through; round-robin pointer unused.
//   - rst_n low mid-frame: tx_en drops immediately; counters cleared; no tx_abort pulse.
//   - ch_valid/ch_last on non-granted channels: ignored.
// STRUCTURE
//  mac_pkg:
//   - typedef enum {IDLE, SEND, IFG} tx_sched_state_t
//   - ARB_FIXED/ARB_RR constants
//   - ETH_TYPE_ARP=16'h0806, ETH_TYPE_IPV4=16'h0800
//  Sub-module mac_rr_arbiter (NUM_CH, ARB_MODE):
//   - inputs: eligible vector, pointer
//   - outputs: one-hot winner, index (combinational)
//  Top: state register, IFG/stall counters, output mux, counters.
// TESTING
//  1 Single ARP frame:
//    ch0 req, dest DEADBEEFCAFE, type 0806, 28 bytes, tx_next every cycle
//    -> ch_grant=0001 after 1 cycle, 28 bytes on tx_data in order, frame_cnt=1, tx_en low after last.
//  2 Fixed priority:
//    ch2 and ch1 request in the same cycle, ARB_MODE=0 -> ch1 first;
//    ch2 granted exactly IFG_CYCLES+1 cycles after ch1 last.
//  3 Round-robin:
//    ARB_MODE=1, all 4 channels request continuously -> grant order 0,1,2,3,0; no channel starved.
//  4 Hold gating:
//    ch0 req with ch_hold=1 for 20 cycles -> no grant; grant 1 cycle after hold falls.
//    ch3 req raised meanwhile -> ch3 served first.
//  5 Stall abort:
//    STALL_MAX=8, ch0 sends 3 bytes then ch_valid=0 with tx_next=1
//    -> tx_abort on the 8th stalled cycle, abort_cnt=1, frame_cnt unchanged.
//  6 Reset mid-frame:
//    rst_n low during byte 5 -> tx_en, ch_grant, tx_data, counters 0 asynchronously;
//    after release a pending request is re-granted from IDLE.

Source files
------------

// File: rtl/mac_tx_sched_pkg.sv
// rtl/mac_tx_sched_pkg.sv - shared types and constants for the multi-channel TX frame scheduler
//
// Purpose: scheduler state encoding, arbitration mode selectors, common ethertypes and
// an index-width helper used by the scheduler, its arbiter and its interface.

package mac_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        IFG  = 2'd2
    } tx_sched_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

    // Width of a channel index; a single channel still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_tx_sched_if.sv
// rtl/mac_tx_sched_if.sv - client channel and rgmii_tx facing bundle of the TX scheduler
//
// Purpose: groups the per-channel request/payload signals and the multiplexed TX stream.
// Modports:
//   master - the scheduler: consumes client requests/bytes and tx_next, drives ch_ready,
//            ch_grant and the tx_* stream towards rgmii_tx.
//   slave  - the environment: clients plus rgmii_tx.
// Signals:
//   ch_req/ch_hold/ch_valid/ch_last  per-channel level/qualifier bits
//   ch_dest/ch_ethertype/ch_data     per-channel packed fields, ch i at [W*i +: W]
//   ch_ready/ch_grant                per-channel accept strobe / one-hot ownership
//   tx_en/tx_dest/tx_ethertype/tx_data/tx_abort  towards rgmii_tx
//   tx_next                          byte request from rgmii_tx

interface mac_tx_sched_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH-1:0]    ch_hold;
    logic [NUM_CH*48-1:0] ch_dest;
    logic [NUM_CH*16-1:0] ch_ethertype;
    logic [NUM_CH*8-1:0]  ch_data;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_last;
    logic [NUM_CH-1:0]    ch_ready;
    logic [NUM_CH-1:0]    ch_grant;
    logic                 tx_en;
    logic [47:0]          tx_dest;
    logic [15:0]          tx_ethertype;
    logic [7:0]           tx_data;
    logic                 tx_next;
    logic                 tx_abort;

    modport master (
        input  ch_req, ch_hold, ch_dest, ch_ethertype, ch_data, ch_valid, ch_last, tx_next,
        output ch_ready, ch_grant, tx_en, tx_dest, tx_ethertype, tx_data, tx_abort
    );

    modport slave (
        output ch_req, ch_hold, ch_dest, ch_ethertype, ch_data, ch_valid, ch_last, tx_next,
        input  ch_ready, ch_grant, tx_en, tx_dest, tx_ethertype, tx_data, tx_abort
    );

endinterface

// File: rtl/mac_tx_sched_rr_arbiter.sv
// rtl/mac_tx_sched_rr_arbiter.sv - combinational fixed-priority / round-robin channel picker
//
// Purpose: selects one eligible channel.
//   ARB_MODE = ARB_FIXED : lowest index wins.
//   ARB_MODE = ARB_RR    : search ptr+1 .. ptr+NUM_CH (mod NUM_CH), first eligible wins.
// Ports:
//   eligible   in   NUM_CH  req & ~hold per channel
//   ptr        in   IW      index of the last granted channel (round-robin only)
//   grant_oh   out  NUM_CH  one-hot winner, zero when nothing eligible
//   grant_idx  out  IW      winner index, zero when nothing eligible
//   grant_any  out  1       some channel is eligible

module mac_rr_arbiter
    import mac_tx_sched_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  ARB_MODE = ARB_FIXED,
    localparam int IW       = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [IW-1:0]     ptr,
    output logic [NUM_CH-1:0] grant_oh,
    output logic [IW-1:0]     grant_idx,
    output logic              grant_any
);

    int start;
    int cand;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        // Fixed priority is the same scan with the start pinned to channel 0.
        start     = (ARB_MODE == ARB_RR) ? (int'(ptr) + 1) : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (start + k) % NUM_CH;
            if (!grant_any && eligible[cand]) begin
                grant_any      = 1'b1;
                grant_oh[cand] = 1'b1;
                grant_idx      = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mac_tx_sched.sv
// rtl/mac_tx_sched.sv - multi-channel TX frame scheduler in front of rgmii_tx
//
// Purpose: arbitrates NUM_CH protocol encoders onto one rgmii_tx, gating on ch_hold,
// forcing IFG_CYCLES idle cycles after every frame end or abort, and aborting a frame
// after STALL_MAX consecutive tx_next requests the owning channel cannot serve.
// Ports:
//   clk        in   TX clock
//   rst_n      in   asynchronous active-low reset
//   bus        --   mac_tx_sched_if.master (client channels + rgmii_tx stream)
//   frame_cnt  out  completed frames, wrapping
//   abort_cnt  out  aborted frames, wrapping

module mac_tx_sched
    import mac_tx_sched_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ARB_MODE   = ARB_FIXED,
    parameter int IFG_CYCLES = 12,
    parameter int STALL_MAX  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    mac_tx_sched_if.master    bus,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       abort_cnt
);

    localparam int IW  = idx_width(NUM_CH);
    localparam int SW  = $clog2(STALL_MAX + 1);
    localparam int GW  = $clog2(IFG_CYCLES + 1);

    tx_sched_state_t   state_q, state_d;

    logic [NUM_CH-1:0] grant_q;
    logic [IW-1:0]     grant_idx_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [SW-1:0]     stall_cnt_q;
    logic [GW-1:0]     ifg_cnt_q;
    logic              tx_en_q;
    logic [47:0]       tx_dest_q;
    logic [15:0]       tx_ethertype_q;
    logic [7:0]        tx_data_q;
    logic              tx_abort_q;

    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] arb_oh;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;

    logic              sel_valid;
    logic              sel_last;
    logic [7:0]        sel_data;
    logic              hs;
    logic [NUM_CH-1:0] ready_d;

    logic              do_grant;
    logic              frame_done;
    logic              stall_abort;
    logic              stall_inc;

    assign eligible = bus.ch_req & ~bus.ch_hold;

    mac_rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .eligible  (eligible),
        .ptr       (rr_ptr_q),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Only the owning channel's qualifiers matter; everything else is ignored.
    assign sel_valid = bus.ch_valid[grant_idx_q];
    assign sel_last  = bus.ch_last[grant_idx_q];
    assign sel_data  = bus.ch_data[int'(grant_idx_q)*8 +: 8];
    assign hs        = (state_q == SEND) && bus.tx_next && sel_valid;

    always_comb begin
        ready_d = '0;
        if (hs) begin
            ready_d[grant_idx_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        do_grant    = 1'b0;
        frame_done  = 1'b0;
        stall_abort = 1'b0;
        stall_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    do_grant = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // A byte handshake takes precedence, so a last byte can never be lost
                // to the stall limit.
                if (hs) begin
                    if (sel_last) begin
                        frame_done = 1'b1;
                        state_d    = IFG;
                    end
                end else if (bus.tx_next) begin
                    if (stall_cnt_q == SW'(STALL_MAX - 1)) begin
                        stall_abort = 1'b1;
                        state_d     = IFG;
                    end else begin
                        stall_inc = 1'b1;
                    end
                end
            end
            IFG: begin
                if (ifg_cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            grant_idx_q    <= '0;
            rr_ptr_q       <= IW'(NUM_CH - 1);
            stall_cnt_q    <= '0;
            ifg_cnt_q      <= '0;
            tx_en_q        <= 1'b0;
            tx_dest_q      <= '0;
            tx_ethertype_q <= '0;
            tx_data_q      <= '0;
            tx_abort_q     <= 1'b0;
            frame_cnt      <= '0;
            abort_cnt      <= '0;
        end else begin
            state_q    <= state_d;
            tx_abort_q <= stall_abort;

            if (do_grant) begin
                grant_q        <= arb_oh;
                grant_idx_q    <= arb_idx;
                rr_ptr_q       <= arb_idx;
                tx_dest_q      <= bus.ch_dest[int'(arb_idx)*48 +: 48];
                tx_ethertype_q <= bus.ch_ethertype[int'(arb_idx)*16 +: 16];
                tx_en_q        <= 1'b1;
                stall_cnt_q    <= '0;
            end

            if (hs) begin
                tx_data_q   <= sel_data;
                stall_cnt_q <= '0;
            end else if (stall_inc) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end

            if (frame_done || stall_abort) begin
                tx_en_q     <= 1'b0;
                grant_q     <= '0;
                stall_cnt_q <= '0;
                ifg_cnt_q   <= GW'(IFG_CYCLES - 1);
            end else if (state_q == IFG && ifg_cnt_q != '0) begin
                ifg_cnt_q <= ifg_cnt_q - 1'b1;
            end

            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (stall_abort) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
        end
    end

    assign bus.ch_ready     = ready_d;
    assign bus.ch_grant     = grant_q;
    assign bus.tx_en        = tx_en_q;
    assign bus.tx_dest      = tx_dest_q;
    assign bus.tx_ethertype = tx_ethertype_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_abort     = tx_abort_q;

endmodule

// File: tb/tb_mac_tx_sched.sv
// tb/tb_mac_tx_sched.sv - directed self-checking bench for mac_tx_sched

module tb_mac_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, hold, valid, last;
    logic [31:0] data;
    logic        tx_next;
    logic [191:0] dest;
    logic [63:0]  etype;

    logic [15:0] frame_cnt_a, abort_cnt_a, frame_cnt_b, abort_cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mac_tx_sched_if #(.NUM_CH(4)) ifa ();
    mac_tx_sched_if #(.NUM_CH(4)) ifb ();

    assign ifa.ch_req = req;   assign ifb.ch_req = req;
    assign ifa.ch_hold = hold; assign ifb.ch_hold = hold;
    assign ifa.ch_valid = valid; assign ifb.ch_valid = valid;
    assign ifa.ch_last = last; assign ifb.ch_last = last;
    assign ifa.ch_data = data; assign ifb.ch_data = data;
    assign ifa.ch_dest = dest; assign ifb.ch_dest = dest;
    assign ifa.ch_ethertype = etype; assign ifb.ch_ethertype = etype;
    assign ifa.tx_next = tx_next; assign ifb.tx_next = tx_next;

    mac_tx_sched #(.NUM_CH(4), .ARB_MODE(0), .IFG_CYCLES(12), .STALL_MAX(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.master),
        .frame_cnt(frame_cnt_a), .abort_cnt(abort_cnt_a)
    );

    mac_tx_sched #(.NUM_CH(4), .ARB_MODE(1), .IFG_CYCLES(12), .STALL_MAX(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.master),
        .frame_cnt(frame_cnt_b), .abort_cnt(abort_cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive n bytes base, base+1, ... on channel ch with tx_next every cycle; checks ready
    // before each edge and the byte on tx_data after it.
    task automatic send_bytes(input int ch, input int n, input logic [7:0] base,
                              input bit with_last, input string tag);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << ch;
        for (int i = 0; i < n; i++) begin
            valid[ch]       = 1'b1;
            data[8*ch +: 8] = base + 8'(i);
            last[ch]        = with_last && (i == n - 1);
            tx_next         = 1'b1;
            #1;
            chk({tag, "_ready"}, ifa.ch_ready, exp_rdy);
            tick();
            chk({tag, "_data"}, ifa.tx_data, base + 8'(i));
        end
        valid[ch] = 1'b0;
        last[ch]  = 1'b0;
        tx_next   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] order [5];
    int         n_gr;

    initial begin
        rst_n = 1'b0; req = '0; hold = '0; valid = '0; last = '0; data = '0; tx_next = 1'b0;
        dest  = {48'h0A0B0C0D0E03, 48'h0A0B0C0D0E02, 48'h021122334455, 48'hDEADBEEFCAFE};
        etype = {16'h88B5, 16'h0800, 16'h0800, 16'h0806};
        tick(); tick();
        chk("rst_grant", ifa.ch_grant, 4'b0000);
        chk("rst_tx_en", ifa.tx_en, 1'b0);
        chk("rst_tx_data", ifa.tx_data, 8'h00);
        chk("rst_frame_cnt", frame_cnt_a, 16'd0);
        rst_n = 1'b1;
        tick();

        // 1: single ARP frame on ch0
        req[0] = 1'b1;
        #1;
        chk("t1_pre_grant", ifa.ch_grant, 4'b0000);
        tick();
        chk("t1_grant", ifa.ch_grant, 4'b0001);
        chk("t1_tx_en", ifa.tx_en, 1'b1);
        chk("t1_dest", ifa.tx_dest, 48'hDEADBEEFCAFE);
        chk("t1_type", ifa.tx_ethertype, 16'h0806);
        req[0] = 1'b0;
        send_bytes(0, 28, 8'h40, 1'b1, "t1");
        chk("t1_tx_en_off", ifa.tx_en, 1'b0);
        chk("t1_grant_off", ifa.ch_grant, 4'b0000);
        chk("t1_frame_cnt", frame_cnt_a, 16'd1);

        // 2: fixed priority, requests raised during IFG wait IFG_CYCLES+1 cycles
        req[1] = 1'b1; req[2] = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 12) chk("t2_ifg_hold", ifa.ch_grant, 4'b0000);
        end
        chk("t2_grant_ch1", ifa.ch_grant, 4'b0010);
        chk("t2_dest_ch1", ifa.tx_dest, 48'h021122334455);
        req[1] = 1'b0;
        send_bytes(1, 4, 8'h10, 1'b1, "t2a");
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 12) chk("t2_ch2_early", ifa.ch_grant, 4'b0000);
        end
        chk("t2_grant_ch2", ifa.ch_grant, 4'b0100);
        req[2] = 1'b0;
        send_bytes(2, 3, 8'h20, 1'b1, "t2b");
        chk("t2_frame_cnt", frame_cnt_a, 16'd3);

        // 3: round-robin from reset, all channels streaming 1-byte frames
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t3_rst_cnt", frame_cnt_b, 16'd0);
        req = 4'b1111; valid = 4'b1111; last = 4'b1111; tx_next = 1'b1;
        data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        n_gr = 0;
        for (int t = 0; t < 100 && n_gr < 5; t++) begin
            tick();
            if (ifb.ch_grant != 4'b0000) begin
                order[n_gr] = ifb.ch_grant;
                n_gr++;
            end
        end
        chk("t3_n_grants", 64'(n_gr), 64'd5);
        chk("t3_rr0", order[0], 4'b0001);
        chk("t3_rr1", order[1], 4'b0010);
        chk("t3_rr2", order[2], 4'b0100);
        chk("t3_rr3", order[3], 4'b1000);
        chk("t3_rr4", order[4], 4'b0001);
        req = '0;
        tick();
        chk("t3_frames_b", frame_cnt_b, 16'd5);
        chk("t3_frames_a", frame_cnt_a, 16'd5);
        tick();
        valid = '0; last = '0; tx_next = 1'b0;
        for (int k = 0; k < 20; k++) tick();

        // 4: hold gating, ch3 served while ch0 is held
        req[0] = 1'b1; hold[0] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("t4_held_idle", ifa.ch_grant, 4'b0000);
        req[3] = 1'b1;
        tick();
        chk("t4_grant_ch3", ifa.ch_grant, 4'b1000);
        chk("t4_type_ch3", ifa.tx_ethertype, 16'h88B5);
        req[3] = 1'b0;
        send_bytes(3, 2, 8'h30, 1'b1, "t4a");
        for (int k = 0; k < 12; k++) tick();
        chk("t4_still_held", ifa.ch_grant, 4'b0000);
        hold[0] = 1'b0;
        tick();
        chk("t4_grant_ch0", ifa.ch_grant, 4'b0001);
        req[0] = 1'b0;
        send_bytes(0, 2, 8'h50, 1'b1, "t4b");
        chk("t4_frame_cnt", frame_cnt_a, 16'd7);

        // 5: stall abort after 8 counted stall cycles; tx_next=0 cycles do not count
        req[0] = 1'b1;
        for (int k = 0; k < 13; k++) tick();
        chk("t5_grant", ifa.ch_grant, 4'b0001);
        req[0] = 1'b0;
        send_bytes(0, 3, 8'h60, 1'b0, "t5");
        tx_next = 1'b1;
        #1;
        chk("t5_ready_stall", ifa.ch_ready, 4'b0000);
        for (int k = 0; k < 4; k++) tick();
        tx_next = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("t5_pause_en", ifa.tx_en, 1'b1);
        tx_next = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("t5_abort_early", ifa.tx_abort, 1'b0);
        chk("t5_grant_early", ifa.ch_grant, 4'b0001);
        tick();
        chk("t5_abort", ifa.tx_abort, 1'b1);
        chk("t5_tx_en", ifa.tx_en, 1'b0);
        chk("t5_grant_off", ifa.ch_grant, 4'b0000);
        chk("t5_abort_cnt", abort_cnt_a, 16'd1);
        chk("t5_frame_cnt", frame_cnt_a, 16'd7);
        tick();
        chk("t5_abort_pulse", ifa.tx_abort, 1'b0);
        tx_next = 1'b0;

        // 6: asynchronous reset mid-frame, then re-grant from IDLE
        req[0] = 1'b1;
        for (int k = 0; k < 13; k++) tick();
        chk("t6_grant", ifa.ch_grant, 4'b0001);
        send_bytes(0, 5, 8'h70, 1'b0, "t6");
        valid[0] = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_en", ifa.tx_en, 1'b0);
        chk("t6_async_grant", ifa.ch_grant, 4'b0000);
        chk("t6_async_data", ifa.tx_data, 8'h00);
        chk("t6_async_fcnt", frame_cnt_a, 16'd0);
        chk("t6_async_acnt", abort_cnt_a, 16'd0);
        chk("t6_async_abort", ifa.tx_abort, 1'b0);
        valid[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_regrant", ifa.ch_grant, 4'b0001);
        chk("t6_no_abort", ifa.tx_abort, 1'b0);
        req[0] = 1'b0;
        send_bytes(0, 1, 8'h90, 1'b1, "t6b");
        chk("t6_frame_cnt", frame_cnt_a, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
